calibration_sequencer: RTL and testbench
========================================

CALIBRATION_SEQUENCER -- requirements
Module: calibration_sequencer

Interface
REQ-001 Parameter ADC_COUNT, default 8, SHALL give the number of ADC channels calibrated per run (1..16).
REQ-002 Parameter RESULT_WIDTH, default 16, SHALL give the stored mean width.
REQ-003 Parameter TIMEOUT_CYCLES, default 2**24, SHALL give the sysClk cycles allowed per channel before the sequencer declares a timeout.
REQ-004 sysClk  in  1  sole clock; every register SHALL be updated on its rising edge.
REQ-005 sysReset_n  in  1  synchronous, active-low reset.
REQ-006 csrStrobe  in  1  one-cycle CSR write qualifier.
REQ-007 GPIO_OUT  in  32  CSR write data: [31] start, [30] training enable, [29] abort, [27:24] readback index.
REQ-008 readout  out  32  status: {busy, trainingOn, timeoutErr, done, index[3:0], 8'b0, mean[15:0]}.
REQ-009 calStrobe  out  1  one-cycle write strobe to the downstream mean-measurement block.
REQ-010 calCommand  out  32  command word to that block: [31] start, [30] training, [27:24] channel, all other bits 0.
REQ-011 calReadout  in  32  status from that block: [31] busy, [15:0] mean value.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE, NEXT.
REQ-013 IDLE + csrStrobe + GPIO_OUT[31] + !GPIO_OUT[29]: channel<=0, done<=0, timeoutErr<=0, busy<=1, go to ISSUE.
REQ-014 ISSUE: calStrobe=1 for exactly one cycle, calCommand={1, trainingOn, 2'b0, channel, 24'b0}; next state WAIT_BUSY, timeout counter cleared.
REQ-015 WAIT_BUSY: calReadout[31]=1 -> WAIT_DONE; after 4 cycles without it -> timeoutErr<=1, busy<=0, IDLE.
REQ-016 WAIT_DONE: calReadout[31]=0 -> CAPTURE; counter reaching TIMEOUT_CYCLES-1 -> timeoutErr<=1, busy<=0, IDLE.
REQ-017 CAPTURE: result[channel] <= calReadout[RESULT_WIDTH-1:0]; next NEXT.
REQ-018 NEXT: channel==ADC_COUNT-1 -> done<=1, busy<=0, IDLE; else channel+1 -> ISSUE.
REQ-019 A csrStrobe with GPIO_OUT[29] in any non-IDLE state SHALL return to IDLE next cycle, busy<=0, done<=0, results retained; abort SHALL win over a simultaneous start.
REQ-020 start while busy SHALL be ignored; trainingOn and index SHALL still update on every csrStrobe.
REQ-021 csrStrobe in IDLE without start SHALL issue one calStrobe the next cycle with calCommand start=0 so the training setting propagates; in non-IDLE states training reaches the downstream block at the next ISSUE.
REQ-022 readout mean field SHALL show result[index], registered, one cycle after index changes; index >= ADC_COUNT SHALL read 0.
REQ-023 readout[27:24] SHALL show index, not the running channel.
REQ-024 Timeout counter SHALL saturate, never wrap; channel counter width SHALL be $clog2(ADC_COUNT) padded to 4 bits.
REQ-025 calStrobe SHALL never be asserted on two consecutive cycles.

Reset
REQ-026 sysReset_n=0 SHALL force IDLE, calStrobe=0, calCommand=0, busy=0, done=0, timeoutErr=0, trainingOn=0, index=0, channel=0, all results=0, readout=0, regardless of state.
REQ-027 Reset mid-run SHALL not generate any calStrobe on release.

Structure
REQ-028 CSR bit positions, state encoding and default TIMEOUT_CYCLES SHALL live in a shared package calibration_pkg.
REQ-029 Result storage with registered read port SHALL be sub-module calibration_result_store (ADC_COUNT x RESULT_WIDTH, one write, one read port).

Verification
REQ-030 Start with behavioural model (busy 1 cycle after strobe, 100 cycles busy, mean=0x1000+ch), ADC_COUNT=8 -> 8 strobes with channels 0..7, done=1, index 5 reads 0x1005.
REQ-031 Model never asserts busy -> timeoutErr=1, busy=0 on 5th cycle after calStrobe, no further strobes.
REQ-032 Abort while waiting on channel 3 -> IDLE next cycle, done=0, result[0..2] retained, result[3] unchanged.
REQ-033 Start+abort same strobe in IDLE -> no calStrobe, busy stays 0.
REQ-034 Training-only write (GPIO_OUT=0x40000000) in IDLE -> single calStrobe, calCommand=0x40000000, readout[30]=1.
REQ-035 sysReset_n low during WAIT_DONE -> all outputs 0 next cycle, results cleared, no calStrobe after release.

Source files
------------

// File: rtl/calibration_pkg.sv
// Shared definitions for the calibration sequencer: CSR/status bit positions,
// FSM state encoding, default timeout and command/status word builders.
package calibration_pkg;

  localparam int CSR_START_BIT = 31;
  localparam int CSR_TRAIN_BIT = 30;
  localparam int CSR_ABORT_BIT = 29;
  localparam int CSR_INDEX_LSB = 24;

  localparam int STAT_BUSY_BIT    = 31;
  localparam int STAT_TRAIN_BIT   = 30;
  localparam int STAT_TIMEOUT_BIT = 29;
  localparam int STAT_DONE_BIT    = 28;
  localparam int STAT_INDEX_LSB   = 24;

  localparam int CAL_BUSY_BIT = 31;

  localparam int DEFAULT_TIMEOUT_CYCLES = 2**24;
  localparam int WAIT_BUSY_CYCLES       = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_NEXT      = 3'd5
  } cal_state_e;

  function automatic logic [31:0] build_command(input logic       start,
                                                input logic       training,
                                                input logic [3:0] channel);
    logic [31:0] cmd;
    cmd                         = 32'h0000_0000;
    cmd[CSR_START_BIT]          = start;
    cmd[CSR_TRAIN_BIT]          = training;
    cmd[CSR_INDEX_LSB +: 4]     = channel;
    return cmd;
  endfunction

  function automatic logic [31:0] build_status(input logic        busy,
                                               input logic        training,
                                               input logic        timeout_err,
                                               input logic        done,
                                               input logic [3:0]  index,
                                               input logic [15:0] mean);
    logic [31:0] stat;
    stat                        = 32'h0000_0000;
    stat[STAT_BUSY_BIT]         = busy;
    stat[STAT_TRAIN_BIT]        = training;
    stat[STAT_TIMEOUT_BIT]      = timeout_err;
    stat[STAT_DONE_BIT]         = done;
    stat[STAT_INDEX_LSB +: 4]   = index;
    stat[15:0]                  = mean;
    return stat;
  endfunction

endpackage

// File: rtl/calibration_result_store.sv
// Per-channel mean storage: one write port, one registered read port that
// returns zero for addresses beyond the populated depth.
module calibration_result_store
  import calibration_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [WIDTH-1:0] mem_r [2**AW];
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign wr_ok_s = wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok_s = ({1'b0, rd_addr} < DEPTH_L);

  // storage array and registered read port, all cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem_r[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_addr[AW-1:0]] <= wr_data;
      end
      if (rd_ok_s) begin
        rd_data <= mem_r[rd_addr[AW-1:0]];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: rtl/calibration_sequencer.sv
// Walks every ADC channel through the downstream mean-measurement block,
// stores each mean and exposes status plus a selectable result over one CSR.
module calibration_sequencer
  import calibration_pkg::*;
#(
  parameter int ADC_COUNT      = 8,
  parameter int RESULT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        sysClk,
  input  logic        sysReset_n,
  input  logic        csrStrobe,
  input  logic [31:0] GPIO_OUT,
  output logic [31:0] readout,
  output logic        calStrobe,
  output logic [31:0] calCommand,
  input  logic [31:0] calReadout
);

  localparam int CW     = (ADC_COUNT > 1) ? $clog2(ADC_COUNT) : 1;
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES);
  localparam int TW     = (TW_RAW < 3) ? 3 : TW_RAW;

  localparam logic [CW-1:0] LAST_CH  = CW'(ADC_COUNT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] WB_LAST  = TW'(WAIT_BUSY_CYCLES - 1);
  localparam logic [TW-1:0] TMO_SAT  = {TW{1'b1}};

  cal_state_e        state_r;
  cal_state_e        state_next_s;
  logic [CW-1:0]     channel_r;
  logic [CW-1:0]     channel_next_s;
  logic [TW-1:0]     tcnt_r;
  logic [TW-1:0]     tcnt_next_s;
  logic              busy_r;
  logic              busy_next_s;
  logic              done_r;
  logic              done_next_s;
  logic              timeout_err_r;
  logic              timeout_next_s;
  logic              training_on_r;
  logic              training_next_s;
  logic [3:0]        index_r;
  logic [3:0]        index_next_s;
  logic              cal_strobe_r;
  logic              strobe_next_s;
  logic [31:0]       cal_command_r;
  logic [31:0]       command_next_s;
  logic              train_strobe_s;
  logic              store_wr_s;
  logic [RESULT_WIDTH-1:0] mean_raw_s;

  logic csr_start_s;
  logic csr_abort_s;
  logic cal_busy_s;
  logic unused_inputs_s;

  assign csr_start_s     = csrStrobe && GPIO_OUT[CSR_START_BIT];
  assign csr_abort_s     = csrStrobe && GPIO_OUT[CSR_ABORT_BIT];
  assign cal_busy_s      = calReadout[CAL_BUSY_BIT];
  assign training_next_s = csrStrobe ? GPIO_OUT[CSR_TRAIN_BIT] : training_on_r;
  assign index_next_s    = csrStrobe ? GPIO_OUT[CSR_INDEX_LSB +: 4] : index_r;
  assign unused_inputs_s = ^{GPIO_OUT[28], GPIO_OUT[23:0], calReadout[30:RESULT_WIDTH]};

  // FSM state register
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic; abort outranks everything outside IDLE
  always_comb begin
    state_next_s = state_r;
    if (csr_abort_s && (state_r != ST_IDLE)) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (csr_start_s && !csr_abort_s) begin
            state_next_s = ST_ISSUE;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        // ISSUE holds until its strobe has gone out, so a strobe issued the
        // previous cycle never sits back-to-back with the channel strobe
        ST_ISSUE: begin
          if (cal_strobe_r) begin
            state_next_s = ST_WAIT_BUSY;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end
        ST_WAIT_BUSY: begin
          if (cal_busy_s) begin
            state_next_s = ST_WAIT_DONE;
          end else if (tcnt_r >= WB_LAST) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_BUSY;
          end
        end
        ST_WAIT_DONE: begin
          if (!cal_busy_s) begin
            state_next_s = ST_CAPTURE;
          end else if (tcnt_r >= TMO_LAST) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_DONE;
          end
        end
        ST_CAPTURE: state_next_s = ST_NEXT;
        ST_NEXT: begin
          if (channel_r == LAST_CH) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // per-state control and next values of the registered outputs
  always_comb begin
    channel_next_s = channel_r;
    tcnt_next_s    = tcnt_r;
    busy_next_s    = busy_r;
    done_next_s    = done_r;
    timeout_next_s = timeout_err_r;
    train_strobe_s = 1'b0;
    store_wr_s     = 1'b0;
    if (csr_abort_s && (state_r != ST_IDLE)) begin
      busy_next_s = 1'b0;
      done_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (csr_start_s && !csr_abort_s) begin
            channel_next_s = '0;
            done_next_s    = 1'b0;
            timeout_next_s = 1'b0;
            busy_next_s    = 1'b1;
          end else if (csrStrobe && !GPIO_OUT[CSR_START_BIT]) begin
            train_strobe_s = 1'b1;
          end else begin
            train_strobe_s = 1'b0;
          end
        end
        ST_ISSUE: tcnt_next_s = '0;
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (tcnt_r != TMO_SAT) begin
            tcnt_next_s = tcnt_r + TW'(1);
          end else begin
            tcnt_next_s = tcnt_r;
          end
          if (state_next_s == ST_IDLE) begin
            timeout_next_s = 1'b1;
            busy_next_s    = 1'b0;
          end else begin
            timeout_next_s = timeout_err_r;
          end
        end
        ST_CAPTURE: store_wr_s = 1'b1;
        ST_NEXT: begin
          if (channel_r == LAST_CH) begin
            done_next_s = 1'b1;
            busy_next_s = 1'b0;
          end else begin
            channel_next_s = channel_r + CW'(1);
          end
        end
        default: busy_next_s = 1'b0;
      endcase
    end

    strobe_next_s  = !cal_strobe_r && ((state_next_s == ST_ISSUE) || train_strobe_s);
    command_next_s = cal_command_r;
    if (strobe_next_s) begin
      if (state_next_s == ST_ISSUE) begin
        command_next_s = build_command(1'b1, training_next_s, 4'(channel_next_s));
      end else begin
        command_next_s = build_command(1'b0, training_next_s, 4'b0000);
      end
    end else begin
      command_next_s = cal_command_r;
    end
  end

  // datapath and output registers
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      channel_r     <= '0;
      tcnt_r        <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      training_on_r <= 1'b0;
      index_r       <= 4'h0;
      cal_strobe_r  <= 1'b0;
      cal_command_r <= 32'h0000_0000;
    end else begin
      channel_r     <= channel_next_s;
      tcnt_r        <= tcnt_next_s;
      busy_r        <= busy_next_s;
      done_r        <= done_next_s;
      timeout_err_r <= timeout_next_s;
      training_on_r <= training_next_s;
      index_r       <= index_next_s;
      cal_strobe_r  <= strobe_next_s;
      cal_command_r <= command_next_s;
    end
  end

  calibration_result_store #(
    .DEPTH (ADC_COUNT),
    .WIDTH (RESULT_WIDTH)
  ) u_store (
    .clk     (sysClk),
    .rst_n   (sysReset_n),
    .wr_en   (store_wr_s),
    .wr_addr (4'(channel_r)),
    .wr_data (calReadout[RESULT_WIDTH-1:0]),
    .rd_addr (index_r),
    .rd_data (mean_raw_s)
  );

  assign calStrobe  = cal_strobe_r;
  assign calCommand = cal_command_r;
  assign readout    = build_status(busy_r, training_on_r, timeout_err_r, done_r,
                                   index_r, 16'(mean_raw_s));

endmodule

// File: tb/tb_calibration_sequencer.sv
// Directed bench for calibration_sequencer with a behavioural model of the
// downstream mean-measurement block.
module tb_calibration_sequencer;

  logic        sysClk = 1'b0;
  logic        sysReset_n = 1'b0;
  logic        csrStrobe = 1'b0;
  logic [31:0] GPIO_OUT = 32'h0;
  logic [31:0] readout;
  logic        calStrobe;
  logic [31:0] calCommand;
  logic [31:0] calReadout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // downstream model and strobe monitor state
  int          busy_cnt = 0;
  logic [15:0] model_mean = 16'h0;
  logic [15:0] model_base = 16'h1000;
  bit          never_busy = 1'b0;
  int          strobe_count = 0;
  int          start_count = 0;
  int          consec_cnt = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] cmd_log [64];

  int snap;
  int first;

  calibration_sequencer dut (
    .sysClk     (sysClk),
    .sysReset_n (sysReset_n),
    .csrStrobe  (csrStrobe),
    .GPIO_OUT   (GPIO_OUT),
    .readout    (readout),
    .calStrobe  (calStrobe),
    .calCommand (calCommand),
    .calReadout (calReadout)
  );

  always #5 sysClk = ~sysClk;

  assign calReadout = {(busy_cnt != 0), 15'h0, model_mean};

  // busy rises the cycle after a start strobe and stays up for 100 cycles
  always @(posedge sysClk) begin
    prev_strobe <= calStrobe;
    if (calStrobe && prev_strobe) consec_cnt <= consec_cnt + 1;
    if (calStrobe) strobe_count <= strobe_count + 1;
    if (calStrobe && calCommand[31]) begin
      cmd_log[start_count % 64] <= calCommand;
      start_count <= start_count + 1;
    end
    if (calStrobe && calCommand[31] && !never_busy) begin
      busy_cnt   <= 100;
      model_mean <= model_base + {12'h000, calCommand[27:24]};
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [31:0] data);
    @(negedge sysClk);
    GPIO_OUT  = data;
    csrStrobe = 1'b1;
    @(negedge sysClk);
    csrStrobe = 1'b0;
    GPIO_OUT  = 32'h0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sysClk);
  endtask

  initial begin
    // reset state
    cycles(3);
    check("reset_readout", readout, 32'h0000_0000);
    check("reset_strobe", {31'h0, calStrobe}, 32'h0);
    check("reset_command", calCommand, 32'h0000_0000);
    sysReset_n = 1'b1;
    cycles(2);

    // training-only write in IDLE
    snap = strobe_count;
    csr_write(32'h4000_0000);
    check("train_strobe", {31'h0, calStrobe}, 32'h1);
    check("train_command", calCommand, 32'h4000_0000);
    check("train_readout", readout, 32'h4000_0000);
    cycles(1);
    check("train_strobe_one_cycle", {31'h0, calStrobe}, 32'h0);
    cycles(3);
    check("train_strobe_count", strobe_count - snap, 32'd1);

    // full run over 8 channels, with a start mid-run that must be ignored
    model_base = 16'h1000;
    first = start_count;
    csr_write(32'hC000_0000);
    check("run_first_command", calCommand, 32'hC000_0000);
    cycles(50);
    csr_write(32'hC000_0000);
    for (int i = 0; i < 3000; i++) begin
      if (readout[28]) break;
      @(negedge sysClk);
    end
    check("run_done_reached", {31'h0, readout[28]}, 32'h1);
    check("run_start_strobes", start_count - first, 32'd8);
    for (int ch = 0; ch < 8; ch++) begin
      check($sformatf("run_cmd_ch%0d", ch), cmd_log[(first + ch) % 64],
            32'hC000_0000 | (ch << 24));
    end
    check("run_done_readout", readout, 32'h5000_1000);
    csr_write(32'h4500_0000);
    cycles(1);
    check("read_index5", readout, 32'h5500_1005);
    csr_write(32'h4C00_0000);
    cycles(1);
    check("read_index12_oob", readout, 32'h5C00_0000);
    csr_write(32'h4000_0000);
    cycles(1);
    check("read_index0", readout, 32'h5000_1000);
    cycles(5);

    // downstream never asserts busy
    never_busy = 1'b1;
    snap = strobe_count;
    csr_write(32'hC000_0000);
    check("tmo_strobe", {31'h0, calStrobe}, 32'h1);
    cycles(4);
    check("tmo_cycle4_flags", {28'h0, readout[31:28]}, 32'hC);
    cycles(1);
    check("tmo_cycle5_readout", readout, 32'h6000_1000);
    cycles(20);
    check("tmo_no_more_strobes", strobe_count - snap, 32'd1);
    never_busy = 1'b0;

    // abort while channel 3 is being measured
    model_base = 16'h2000;
    first = start_count;
    csr_write(32'hC000_0000);
    for (int i = 0; i < 1000; i++) begin
      if (start_count - first >= 4) break;
      @(negedge sysClk);
    end
    check("abort_reached_ch3", start_count - first, 32'd4);
    cycles(10);
    snap = strobe_count;
    csr_write(32'h6000_0000);
    check("abort_readout", readout, 32'h4000_2000);
    cycles(20);
    check("abort_no_strobes", strobe_count - snap, 32'd0);
    csr_write(32'h4100_0000);
    cycles(1);
    check("abort_keep_r1", readout, 32'h4100_2001);
    csr_write(32'h4200_0000);
    cycles(1);
    check("abort_keep_r2", readout, 32'h4200_2002);
    csr_write(32'h4300_0000);
    cycles(1);
    check("abort_r3_unchanged", readout, 32'h4300_1003);
    cycles(120);

    // start and abort on the same strobe in IDLE
    snap = strobe_count;
    csr_write(32'hE000_0000);
    cycles(5);
    check("startabort_no_strobe", strobe_count - snap, 32'd0);
    check("startabort_flags", {28'h0, readout[31:28]}, 32'h4);

    // reset during WAIT_DONE
    model_base = 16'h3000;
    first = start_count;
    csr_write(32'hC000_0000);
    for (int i = 0; i < 1000; i++) begin
      if (start_count - first >= 2) break;
      @(negedge sysClk);
    end
    check("rst_reached_ch1", start_count - first, 32'd2);
    cycles(10);
    sysReset_n = 1'b0;
    cycles(1);
    check("rst_readout", readout, 32'h0000_0000);
    check("rst_strobe", {31'h0, calStrobe}, 32'h0);
    check("rst_command", calCommand, 32'h0000_0000);
    cycles(2);
    sysReset_n = 1'b1;
    snap = strobe_count;
    cycles(150);
    check("rst_no_strobe_after", strobe_count - snap, 32'd0);
    csr_write(32'h0000_0000);
    cycles(1);
    check("rst_results_cleared", readout, 32'h0000_0000);

    check("no_back_to_back_strobe", consec_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
